// File: rtl/conv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_arb_pkg
// Description : Shared types for the convolution-engine arbiter: the FSM
//               state encoding, the row width in bytes and the byte type.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_arb_pkg;

    localparam int ROW_BYTES = 16;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Search starts at
//               (last_i + 1) mod NREQ and wraps; the first set request wins.
// Ports       : req_i       - request vector
//               last_i      - index of the previous winner
//               gnt_o       - one-hot grant (zero when no request)
//               gnt_idx_o   - binary index of the winner
//               gnt_valid_o - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_valid_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        // k runs 1..NREQ so the previous winner is examined last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        gnt_valid_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conv_arbiter
// Description : Shares one convolution engine among NREQ requesters. A
//               16-byte row is accepted from the round-robin winner, sent to
//               the engine as CHUNKS = 16/N chunks (one outstanding at a
//               time), reassembled, and returned to the same requester.
// Ports       : clk, reset (async, active-low)
//               valid_i/ready_i/i        - request side (ready_i is an output)
//               valid_o/ready_o/o        - result side (ready_o is an input)
//               conv_valid_i/conv_in     - chunk launch to engine
//               conv_valid_o/conv_out    - chunk result from engine
//               grant_id                 - requester currently served
//               busy                     - transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module conv_arbiter
    import conv_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int N    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic  [NREQ-1:0]                     valid_i,
    output logic  [NREQ-1:0]                     ready_i,
    input  byte_t [NREQ-1:0][ROW_BYTES-1:0]      i,
    output logic  [NREQ-1:0]                     valid_o,
    input  logic  [NREQ-1:0]                     ready_o,
    output byte_t [ROW_BYTES-1:0]                o,
    output logic                                 conv_valid_i,
    output byte_t [N-1:0]                        conv_in,
    input  logic                                 conv_valid_o,
    input  byte_t [N-1:0]                        conv_out,
    output logic  [$clog2(NREQ)-1:0]             grant_id,
    output logic                                 busy
);

    localparam int CHUNKS = ROW_BYTES / N;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IW     = $clog2(NREQ);
    localparam int W      = N * 8;
    localparam int RW     = ROW_BYTES * 8;

    state_t          state_q, state_d;
    logic [CW-1:0]   idx_q,   idx_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [RW-1:0]   row_q,   row_d;
    logic [RW-1:0]   res_q,   res_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i       (valid_i),
        .last_i      (last_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            // Pointer starts at the top so requester 0 wins the first round.
            last_q  <= IW'(NREQ - 1);
            row_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            row_q   <= row_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        grant_d      = grant_q;
        last_d       = last_q;
        row_d        = row_q;
        res_d        = res_q;
        ready_i      = '0;
        valid_o      = '0;
        conv_valid_i = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    ready_i = arb_gnt;
                    grant_d = arb_idx;
                    row_d   = i[arb_idx];
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                conv_valid_i = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // Engine results are only consumed here, so a stray
                // conv_valid_o in any other state cannot corrupt the row.
                if (conv_valid_o) begin
                    res_d[int'(idx_q)*W +: W] = conv_out;
                    if (idx_q == CW'(CHUNKS - 1)) begin
                        idx_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        state_d = S_SEND;
                    end
                end
            end
            S_WRITE: begin
                valid_o[grant_q] = 1'b1;
                if (ready_o[grant_q]) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign conv_in  = row_q[int'(idx_q)*W +: W];
    assign o        = res_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_arbiter
// Description : Self-checking bench. A 4-byte-chunk instance (engine latency
//               3) is checked every cycle against a transaction-level model;
//               a 16-byte-chunk instance (latency 1) gets directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_arbiter;

    localparam int NREQ  = 2;
    localparam int N4    = 4;
    localparam int L4    = 3;
    localparam int CH4   = 16 / N4;
    localparam int DONE4 = 1 + CH4 * (1 + L4);

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance with N = 4, engine latency 3 -----------------
    logic [1:0]           valid_i, ready_i, valid_o, ready_o;
    logic [1:0][15:0][7:0] row_i;
    logic [15:0][7:0]     o;
    logic                 cvi, cvo, spur;
    logic [3:0][7:0]      cin, cout;
    logic                 gid, busy;
    logic [L4-1:0]        pv = '0;
    logic [L4-1:0][31:0]  pd = '0;

    function automatic logic [31:0] add2_4(input logic [3:0][7:0] x);
        logic [3:0][7:0] r;
        for (int b = 0; b < 4; b++) r[b] = x[b] + 8'd2;
        return r;
    endfunction

    function automatic logic [127:0] add2_16(input logic [15:0][7:0] x);
        logic [15:0][7:0] r;
        for (int b = 0; b < 16; b++) r[b] = x[b] + 8'd2;
        return r;
    endfunction

    // Engine: adds 2 to every byte, result appears L4 cycles after launch.
    always @(posedge clk) begin
        pv <= {pv[L4-2:0], cvi};
        pd <= {pd[L4-2:0], add2_4(cin)};
    end
    assign cvo  = pv[L4-1] | spur;
    assign cout = spur ? 32'hFFFF_FFFF : pd[L4-1];

    conv_arbiter #(.NREQ(NREQ), .N(N4)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .valid_i      (valid_i),
        .ready_i      (ready_i),
        .i            (row_i),
        .valid_o      (valid_o),
        .ready_o      (ready_o),
        .o            (o),
        .conv_valid_i (cvi),
        .conv_in      (cin),
        .conv_valid_o (cvo),
        .conv_out     (cout),
        .grant_id     (gid),
        .busy         (busy)
    );

    // ---------------- instance with N = 16, engine latency 1 ----------------
    logic [1:0]            v16, rdy16, vo16, ro16;
    logic [1:0][15:0][7:0] row16;
    logic [15:0][7:0]      o16, cin16, cout16;
    logic                  cvi16, cvo16, gid16, busy16;
    logic                  p16v = 1'b0;
    logic [127:0]          p16d = '0;

    always @(posedge clk) begin
        p16v <= cvi16;
        p16d <= add2_16(cin16);
    end
    assign cvo16  = p16v;
    assign cout16 = p16d;

    conv_arbiter #(.NREQ(NREQ), .N(16)) dut16 (
        .clk          (clk),
        .reset        (rst_n),
        .valid_i      (v16),
        .ready_i      (rdy16),
        .i            (row16),
        .valid_o      (vo16),
        .ready_o      (ro16),
        .o            (o16),
        .conv_valid_i (cvi16),
        .conv_in      (cin16),
        .conv_valid_o (cvo16),
        .conv_out     (cout16),
        .grant_id     (gid16),
        .busy         (busy16)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [1:0] v, input int last);
        int w;
        for (int k = 1; k <= NREQ; k++) begin
            w = (last + k) % NREQ;
            if (v[w]) return w;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model + per-cycle compare -----------
    bit               m_active = 1'b0;
    int               m_acc = 0;
    int               m_grant = 0;
    int               m_last = NREQ - 1;
    logic [15:0][7:0] m_in  = '0;
    logic [15:0][7:0] m_exp = '0;
    logic [15:0][7:0] m_o   = '0;
    int               c_w, c_rel;
    logic [1:0]       c_eo;
    logic [3:0][7:0]  c_ec;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready_i", 128'(ready_i), 128'(0));
            chk("rst_valid_o", 128'(valid_o), 128'(0));
            chk("rst_conv_valid_i", 128'(cvi), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_grant_id", 128'(gid), 128'(0));
            chk("rst_o", 128'(o), 128'(0));
            m_active = 1'b0;
            m_last   = NREQ - 1;
            m_grant  = 0;
            m_o      = '0;
        end else if (!m_active) begin
            c_w  = rr_pick(valid_i, m_last);
            c_eo = '0;
            if (c_w >= 0) c_eo[c_w] = 1'b1;
            chk("idle_ready_i", 128'(ready_i), 128'(c_eo));
            chk("idle_busy", 128'(busy), 128'(0));
            chk("idle_valid_o", 128'(valid_o), 128'(0));
            chk("idle_conv_valid_i", 128'(cvi), 128'(0));
            chk("idle_o", 128'(o), 128'(m_o));
            chk("idle_grant_id", 128'(gid), 128'(m_grant));
            if (c_w >= 0) begin
                m_active = 1'b1;
                m_acc    = cyc;
                m_grant  = c_w;
                m_in     = row_i[c_w];
                m_exp    = add2_16(row_i[c_w]);
            end
        end else if (cyc < m_acc + DONE4) begin
            // One launch every (1+L) cycles starting the cycle after accept.
            c_rel = cyc - m_acc - 1;
            chk("proc_busy", 128'(busy), 128'(1));
            chk("proc_ready_i", 128'(ready_i), 128'(0));
            chk("proc_valid_o", 128'(valid_o), 128'(0));
            chk("proc_grant_id", 128'(gid), 128'(m_grant));
            chk("proc_conv_valid_i", 128'(cvi), 128'((c_rel % (1 + L4)) == 0));
            if ((c_rel % (1 + L4)) == 0) begin
                for (int j = 0; j < N4; j++) c_ec[j] = m_in[(c_rel / (1 + L4)) * N4 + j];
                chk("proc_conv_in", 128'(cin), 128'(c_ec));
            end
        end else begin
            c_eo = '0;
            c_eo[m_grant] = 1'b1;
            chk("write_busy", 128'(busy), 128'(1));
            chk("write_ready_i", 128'(ready_i), 128'(0));
            chk("write_valid_o", 128'(valid_o), 128'(c_eo));
            chk("write_o", 128'(o), 128'(m_exp));
            chk("write_conv_valid_i", 128'(cvi), 128'(0));
            if (ready_o[m_grant]) begin
                m_last   = m_grant;
                m_o      = m_exp;
                m_active = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus --------------------------------------
    int               n, c0, pulses, ng;
    int               got[6];
    int               exp_ord[6] = '{0, 1, 0, 1, 0, 1};
    logic [15:0][7:0] lit;

    initial begin
        rst_n = 1'b0; valid_i = '0; ready_o = '0; row_i = '0; spur = 1'b0;
        v16 = '0; ro16 = '0; row16 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- N=16, L=1: row of 0x05 from requester 0 ----
        @(negedge clk);
        chk("n16_reset_valid_o", 128'(vo16), 128'(0));
        chk("n16_reset_o", 128'(o16), 128'(0));
        @(posedge clk); #1 row16[0] = {16{8'h05}}; v16 = 2'b01;
        @(negedge clk);
        chk("n16_ready_i", 128'(rdy16), 128'(2'b01));
        c0 = cyc;
        @(posedge clk); #1 v16 = '0; ro16 = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (vo16 == 2'b00 && n < 50);
        chk("n16_latency", 128'(cyc - c0), 128'(3));
        chk("n16_valid_o", 128'(vo16), 128'(2'b01));
        chk("n16_o", 128'(o16), {16{8'h07}});
        @(posedge clk); #1 ro16 = '0;

        // ---- N=4, L=3: requester 1, bytes 0x00..0x0F ----
        @(posedge clk); #1
        for (int b = 0; b < 16; b++) row_i[1][b] = 8'(b);
        valid_i = 2'b10;
        @(negedge clk);
        chk("t1_ready_i", 128'(ready_i), 128'(2'b10));
        c0 = cyc; pulses = 0;
        @(posedge clk); #1 valid_i = '0; row_i[1] = {16{8'hAA}};
        n = 0;
        do begin
            @(negedge clk); n++;
            if (cvi) pulses++;
        end while (valid_o == 2'b00 && n < 100);
        for (int b = 0; b < 16; b++) lit[b] = 8'(b + 2);
        chk("t1_pulses", 128'(pulses), 128'(4));
        chk("t1_latency", 128'(cyc - c0), 128'(17));
        chk("t1_valid_o", 128'(valid_o), 128'(2'b10));
        chk("t1_o", 128'(o), 128'(lit));

        // Stall in WRITE; requester 0 requests and pulses its own ready_o.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1 valid_i = 2'b01; ready_o = (k == 4) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("stall_valid_o", 128'(valid_o), 128'(2'b10));
            chk("stall_o", 128'(o), 128'(lit));
        end
        @(posedge clk); #1 ready_o = 2'b10; valid_i = '0;
        @(posedge clk); #1 ready_o = '0;

        // ---- fairness: both valid continuously ----
        ng = 0; n = 0;
        @(posedge clk); #1 valid_i = 2'b11; ready_o = 2'b11;
        while (ng < 6 && n < 500) begin
            @(negedge clk); n++;
            if (ready_i != 2'b00) begin
                got[ng] = ready_i[1] ? 1 : 0;
                ng++;
            end
        end
        chk("fair_count", 128'(ng), 128'(6));
        @(posedge clk); #1 valid_i = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 100);
        chk("fair_drain", 128'(busy), 128'(0));
        for (int k = 0; k < 6; k++) chk("fair_order", 128'(got[k]), 128'(exp_ord[k]));
        @(posedge clk); #1 ready_o = '0;

        // ---- spurious engine result while idle ----
        @(posedge clk); #1 spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_o", 128'(o), {16{8'hAC}});
        chk("spur_busy", 128'(busy), 128'(0));

        // ---- reset during WAIT of the second chunk ----
        @(posedge clk); #1
        for (int b = 0; b < 16; b++) row_i[0][b] = 8'(8'h10 + b);
        valid_i = 2'b01;
        @(negedge clk);
        @(posedge clk); #1 valid_i = '0;
        pulses = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (cvi) pulses++;
        end while (pulses < 2 && n < 50);
        chk("rst_mid_pulses", 128'(pulses), 128'(2));
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_valid_o", 128'(valid_o), 128'(0));
        end

        @(posedge clk); #1
        for (int b = 0; b < 16; b++) row_i[1][b] = 8'(8'h30 + b);
        valid_i = 2'b10; ready_o = 2'b10;
        @(negedge clk);
        chk("after_rst_ready_i", 128'(ready_i), 128'(2'b10));
        c0 = cyc;
        @(posedge clk); #1 valid_i = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (valid_o == 2'b00 && n < 100);
        for (int b = 0; b < 16; b++) lit[b] = 8'(8'h32 + b);
        chk("after_rst_latency", 128'(cyc - c0), 128'(17));
        chk("after_rst_o", 128'(o), 128'(lit));
        @(posedge clk); #1 ready_o = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing the convolution engine, legal range 2..8.
REQ-002 Parameter N, default 16: bytes per engine transaction; SHALL divide 16; CHUNKS = 16/N.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 valid_i  in  NREQ  per-requester request valid.
REQ-006 ready_i  out  NREQ  per-requester request accepted.
REQ-007 i  in  NREQ x 16 x 8  per-requester 16-byte input row.
REQ-008 valid_o  out  NREQ  per-requester result valid.
REQ-009 ready_o  in  NREQ  per-requester result consumed.
REQ-010 o  out  16 x 8  shared result row; meaningful only for the asserted valid_o bit.
REQ-011 conv_valid_i  out  1  one-cycle pulse launching one chunk into the engine.
REQ-012 conv_in  out  N x 8  chunk to engine.
REQ-013 conv_valid_o  in  1  engine result valid, variable latency >= 1 cycle.
REQ-014 conv_out  in  N x 8  engine result chunk.
REQ-015 grant_id  out  clog2(NREQ)  index of the requester currently served.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, SEND, WAIT, WRITE.
REQ-018 IDLE: if any valid_i set, pick a winner round-robin starting at (last_grant+1) mod NREQ; assert ready_i[winner] only, same cycle; latch i[winner] and winner index; go to SEND.
REQ-019 ready_i SHALL be all-zero outside IDLE and never have more than one bit set.
REQ-020 SEND: pulse conv_valid_i for exactly one cycle with conv_in = bytes [idx*N .. idx*N+N-1] of the latched row; go to WAIT.
REQ-021 WAIT: on conv_valid_o write conv_out into bytes [idx*N ..] of the result register; if idx == CHUNKS-1 go to WRITE and clear idx, else increment idx and go to SEND.
REQ-022 conv_valid_o outside WAIT SHALL be ignored (no state or result change).
REQ-023 WRITE: valid_o[grant] = 1, other bits 0; o = result register, stable until the handshake; on ready_o[grant] set last_grant = grant and return to IDLE.
REQ-024 ready_o of non-granted requesters SHALL have no effect.
REQ-025 Latency, engine latency L, requester accepted at cycle 0: valid_o rises at cycle 1 + CHUNKS*(1+L).
REQ-026 Back-to-back: a new request is accepted no earlier than the cycle after the WRITE handshake (one IDLE cycle minimum).
REQ-027 Fairness: with all requesters continuously valid, each is served exactly once per NREQ consecutive grants.
REQ-028 Request data is not sampled again after acceptance; changes on i[] during processing have no effect.

Reset
REQ-029 On reset low, asynchronously: state IDLE, idx 0, last_grant NREQ-1 (so requester 0 wins first), result register 0, latched row 0.
REQ-030 During and immediately after reset, outputs SHALL be: ready_i 0 until first IDLE evaluation with valid_i, valid_o 0, conv_valid_i 0, busy 0, grant_id 0, o 0.
REQ-031 Reset asserted mid-operation abandons the transaction; late conv_valid_o after reset release SHALL be ignored per REQ-022.

Structure
REQ-032 Package conv_arb_pkg holds the state enum, ROW_BYTES = 16 and the byte type.
REQ-033 One sub-module rr_arbiter (NREQ-bit request, last-grant pointer in, one-hot grant and index out, purely combinational); FSM, idx counter and registers live in conv_arbiter.

Verification
REQ-034 NREQ=2, N=16, engine adds 2 with L=1: req0 row all 0x05 -> valid_o = 2'b01, o all 0x07, at cycle 3.
REQ-035 N=4, L=3: req1 row bytes 0..15 = 0x00..0x0F -> exactly four conv_valid_i pulses, o bytes = 0x02..0x11, valid_o[1] at cycle 17.
REQ-036 Both valid every cycle for 6 grants -> grant order 0,1,0,1,0,1; ready_i never 2'b11.
REQ-037 ready_o held low 10 cycles in WRITE -> o and valid_o stable, no new ready_i; ready_o[other] pulsed -> no effect.
REQ-038 Reset low during WAIT of chunk 2 (N=4), engine returns conv_valid_o afterwards -> outputs at reset values, no valid_o; next request completes correctly.
REQ-039 Spurious conv_valid_o in IDLE with conv_out 0xFF -> result register and o unchanged.
